reg_dump_streamer: RTL and testbench

Hardware register-file dump engine for the single-cycle CPU. On a start pulse it freezes the core and reads register-file entries 0..DUMP_COUNT-1 one at a time through a dedicated read port. Each word goes out on a valid/ready stream as an index/data pair, producing in hardware the same r0..r12 result listing the bench prints. It sits beside the register file and feeds a host or trace sink.

---
 rtl/reg_dump_pkg.sv | 15 +
 rtl/reg_dump_streamer.sv | 85 ++++++++
 tb/tb_reg_dump_streamer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump engine, the register file and the CPU top.
package reg_dump_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int IDX_W_DEF      = 5;
  localparam int DUMP_COUNT_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_streamer.sv
// Register-file dump engine: freezes the core, reads entries 0..DUMP_COUNT-1 through a
// dedicated read port and streams them out as index/data pairs on a valid/ready port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start_i, index counter parked at 0
// READ  | rf_addr_o drives the current index; data captured at next edge
// SEND  | captured word presented on the stream until the sink accepts it
// DONE  | one-cycle done_o pulse, then back to IDLE
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int DATA_W     = reg_dump_pkg::DATA_W_DEF,
  parameter int IDX_W      = reg_dump_pkg::IDX_W_DEF,
  parameter int DUMP_COUNT = reg_dump_pkg::DUMP_COUNT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_COUNT - 1);

  dump_state_t       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [DATA_W-1:0] out_data_q;

  // Sequencer: walks the index, snapshots read data in READ and holds it through SEND.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (start_i) state_q <= ST_READ;
        end
        ST_READ: begin
          out_data_q <= rf_data_i;
          out_idx_q  <= idx_q;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; the read port is parked at 0 outside READ.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    hold_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    out_valid_o = (state_q == ST_SEND);
    rf_addr_o   = (state_q == ST_READ) ? idx_q : '0;
    out_idx_o   = out_idx_q;
    out_data_o  = out_data_q;
    out_last_o  = (state_q == ST_SEND) && (out_idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Randomized bench for reg_dump_streamer: a queue of expected index/data words taken from
// a behavioural register file, checked against every accepted stream word and the timing.
module tb_reg_dump_streamer;
  import reg_dump_pkg::*;

  localparam int DC = 13;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        corrupt = 1'b0;
  logic        hold_o, busy_o, done_o, out_valid_o, out_last_o;
  logic [4:0]  rf_addr_o, out_idx_o;
  logic [31:0] rf_data_i, out_data_o;

  logic        start1 = 1'b0;
  logic        ready1 = 1'b0;
  logic        hold1, busy1, done1, valid1, last1;
  logic [4:0]  addr1, idx1;
  logic [31:0] data1, odata1;

  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_err = 0;

  assign rf_data_i = corrupt ? 32'hDEADBEEF : rf[rf_addr_o];
  assign data1     = rf[addr1];

  always #5 clk_i = ~clk_i;

  reg_dump_streamer #(.DATA_W(32), .IDX_W(5), .DUMP_COUNT(DC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .hold_o(hold_o), .busy_o(busy_o), .done_o(done_o),
    .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_idx_o(out_idx_o), .out_data_o(out_data_o), .out_last_o(out_last_o)
  );

  reg_dump_streamer #(.DATA_W(32), .IDX_W(5), .DUMP_COUNT(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start1),
    .hold_o(hold1), .busy_o(busy1), .done_o(done1),
    .rf_addr_o(addr1), .rf_data_i(data1),
    .out_valid_o(valid1), .out_ready_i(ready1),
    .out_idx_o(idx1), .out_data_o(odata1), .out_last_o(last1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hold"},  hold_o,      0);
    chk({tag, "_busy"},  busy_o,      0);
    chk({tag, "_done"},  done_o,      0);
    chk({tag, "_addr"},  rf_addr_o,   0);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_idx"},   out_idx_o,   0);
    chk({tag, "_data"},  out_data_o,  0);
    chk({tag, "_last"},  out_last_o,  0);
  endtask

  // mode 0: ready high; 1: random ready; 2: word 4 held off 5 cycles;
  // 3: stall every word + corrupt read data in SEND + start pokes; 4: reset at word 6
  task automatic run_dump(input int mode);
    int          exp_i[$];
    logic [31:0] exp_d[$];
    int          cyc, stalls, hold_left, done_at;
    bit          prev_stall, finished;
    logic [4:0]  prev_i;
    logic [31:0] prev_d;
    for (int k = 0; k < DC; k++) begin
      exp_i.push_back(k);
      exp_d.push_back(rf[k]);
    end
    @(negedge clk_i);
    start_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    cyc = 0; stalls = 0; hold_left = 5; done_at = -1;
    prev_stall = 0; finished = 0; prev_i = '0; prev_d = '0;
    while (cyc < 300) begin
      @(negedge clk_i);
      start_i = 1'b0;
      corrupt = 1'b0;
      if (!busy_o) begin
        finished = 1;
        break;
      end
      chk("hold_eq_busy", hold_o, busy_o);
      if (cyc == 0) chk("valid_after_e0", out_valid_o, 0);
      if (cyc == 1) chk("valid_after_e1", out_valid_o, 1);
      if (done_o) begin
        chk("done_words", DC - exp_i.size(), DC);
        chk("done_edge", cyc, 2 * DC + stalls);
        chk("done_no_valid", out_valid_o, 0);
        done_at = cyc;
        if (mode == 3) start_i = 1'b1;
      end else if (out_valid_o) begin
        if (exp_i.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("idx", out_idx_o, exp_i[0]);
          chk("data", out_data_o, exp_d[0]);
          chk("last", out_last_o, exp_i[0] == DC - 1);
          chk("addr_send", rf_addr_o, 0);
          if (prev_stall) begin
            chk("stall_idx", out_idx_o, prev_i);
            chk("stall_data", out_data_o, prev_d);
          end
          if (mode == 4 && exp_i[0] == 6) begin
            #2 rst_i = 1'b1;
            #1 chk_zero("rst_mid");
            @(posedge clk_i);
            @(negedge clk_i);
            chk_zero("rst_held");
            rst_i = 1'b0;
            @(negedge clk_i);
            chk("rst_no_done", done_o, 0);
            chk("rst_idle", busy_o, 0);
            return;
          end
          out_ready_i = 1'b1;
          if (mode == 1) out_ready_i = ($urandom_range(0, 9) < 6);
          if (mode == 2 && exp_i[0] == 4 && hold_left > 0) begin
            out_ready_i = 1'b0;
            hold_left--;
          end
          if (mode == 3) begin
            out_ready_i = prev_stall;
            corrupt = 1'b1;
            if (exp_i[0] == 5) start_i = 1'b1;
          end
          prev_stall = !out_ready_i;
          prev_i = out_idx_o;
          prev_d = out_data_o;
          if (out_ready_i) begin
            void'(exp_i.pop_front());
            void'(exp_d.pop_front());
          end else begin
            stalls++;
          end
        end
      end else begin
        chk("addr_read", rf_addr_o, (exp_i.size() > 0) ? exp_i[0] : 32'hFFFF_FFFF);
        prev_stall = 0;
      end
      cyc++;
    end
    out_ready_i = 1'b0;
    chk("finished", finished, 1);
    chk("done_seen", done_at >= 0, 1);
    chk("idle_edge", cyc, done_at + 1);
    if (mode == 2) chk("bp_done_edge", done_at, 2 * DC + 5);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = k * 3 + 1;
    #2 rst_i = 1'b1;
    #1 chk_zero("rst_async");
    chk("rst_async_busy1", busy1, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
    end

    run_dump(0);
    run_dump(2);
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    run_dump(1);
    run_dump(1);
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    run_dump(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("after_poke_idle", busy_o, 0);
    end
    run_dump(4);
    run_dump(0);

    rf[0] = $urandom;
    @(negedge clk_i);
    start1 = 1'b1;
    ready1 = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start1 = 1'b0;
    chk("dc1_busy_e0", busy1, 1);
    chk("dc1_valid_e0", valid1, 0);
    @(negedge clk_i);
    chk("dc1_valid_e1", valid1, 1);
    chk("dc1_idx", idx1, 0);
    chk("dc1_data", odata1, rf[0]);
    chk("dc1_last", last1, 1);
    @(negedge clk_i);
    chk("dc1_done_e2", done1, 1);
    chk("dc1_valid_e2", valid1, 0);
    @(negedge clk_i);
    chk("dc1_done_e3", done1, 0);
    chk("dc1_idle_e3", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
